// File: rtl/aemb2_fsl_pkg.sv
// Shared types and constants for the aeMB2 FSL responder (cwb side).
package aemb2_fsl_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} fsm_e;

   localparam int unsigned TGA_N   = 1;
   localparam int unsigned TGA_C   = 0;
   localparam int unsigned ST_FAIL = 1;
   localparam int unsigned ST_CMIS = 0;
   localparam int unsigned FSL_W   = 33;

endpackage

// File: rtl/aemb2_fsl_fifo.sv
// Single 33-bit {ctl, data} synchronous FIFO, no fall-through.
// cnt_o port exists only when AEMB2_FSL_OCCUPANCY_EN is defined.
module aemb2_fsl_fifo
   import aemb2_fsl_pkg::*;
#(
   parameter int unsigned Depth = 4,
   parameter int unsigned Aw    = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [FSL_W-1:0] dat_i,
   input  logic             pop_i,
   output logic [FSL_W-1:0] dat_o,
   output logic             full_o,
   output logic             empty_o
`ifdef AEMB2_FSL_OCCUPANCY_EN
  ,output logic [Aw:0]      cnt_o
`endif
);

   logic [FSL_W-1:0] mem_q [Depth];
   logic [FSL_W-1:0] mem_d [Depth];
   logic [Aw-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [Aw:0]      cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   assign full_o  = (cnt_q == (Aw+1)'(Depth));
   assign empty_o = (cnt_q == '0);
   assign dat_o   = mem_q[rd_q];
`ifdef AEMB2_FSL_OCCUPANCY_EN
   assign cnt_o   = cnt_q;
`endif

   // Full blocks push even when a pop happens in the same cycle.
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push_ok) begin
         mem_d[wr_q] = dat_i;
         wr_d        = wr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_d = rd_q + 1'b1;
      end
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/aemb2_cwb_fsl.sv
// aeMB2 FSL responder: cwb put/get decode, per-channel put/get FIFOs, device streams.
// AEMB2_FSL_OCCUPANCY_EN exposes per-channel FIFO counts on fsl_occ_o.
module aemb2_cwb_fsl
   import aemb2_fsl_pkg::*;
#(
   parameter int unsigned NCH   = 4,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      cwb_stb_i,
   input  logic                      cwb_wre_i,
   input  logic [4:0]                cwb_adr_i,
   input  logic [1:0]                cwb_tga_i,
   input  logic [3:0]                cwb_sel_i,
   input  logic [31:0]               cwb_dat_i,
   output logic [31:0]               cwb_dat_o,
   output logic                      cwb_ack_o,
   output logic [1:0]                cwb_tga_o,
   output logic [NCH*32-1:0]         fsl_tx_dat_o,
   output logic [NCH-1:0]            fsl_tx_ctl_o,
   output logic [NCH-1:0]            fsl_tx_vld_o,
   input  logic [NCH-1:0]            fsl_tx_rdy_i,
   input  logic [NCH*32-1:0]         fsl_rx_dat_i,
   input  logic [NCH-1:0]            fsl_rx_ctl_i,
   input  logic [NCH-1:0]            fsl_rx_vld_i,
   output logic [NCH-1:0]            fsl_rx_rdy_o,
   output logic [NCH*2*(AW+1)-1:0]   fsl_occ_o
);

   fsm_e        state_q, state_d;
   logic        ack_q, ack_d;
   logic [31:0] dat_q, dat_d;
   logic [1:0]  tga_q, tga_d;
   logic        req_wre_q, req_wre_d;
   logic [4:0]  req_adr_q, req_adr_d;
   logic [1:0]  req_tga_q, req_tga_d;
   logic [31:0] req_dat_q, req_dat_d;

   logic             req_vld;
   logic             cur_wre;
   logic [4:0]       cur_adr;
   logic [1:0]       cur_tga;
   logic [31:0]      cur_dat;
   logic [NCH-1:0]   ch_hit, tx_push, rx_pop;
   logic             hit_full, hit_empty;
   logic [FSL_W-1:0] hit_head;

   logic [FSL_W-1:0] tx_head [NCH];
   logic [FSL_W-1:0] rx_head [NCH];
   logic [NCH-1:0]   tx_full, tx_empty, rx_full, rx_empty;

   assign req_vld   = cwb_stb_i && (cwb_sel_i == 4'hF);
   assign cwb_ack_o = ack_q;
   assign cwb_dat_o = dat_q;
   assign cwb_tga_o = tga_q;

   always_comb begin
      state_d   = state_q;
      ack_d     = 1'b0;
      dat_d     = dat_q;
      tga_d     = tga_q;
      req_wre_d = req_wre_q;
      req_adr_d = req_adr_q;
      req_tga_d = req_tga_q;
      req_dat_d = req_dat_q;
      tx_push   = '0;
      rx_pop    = '0;
      ch_hit    = '0;
      hit_full  = 1'b0;
      hit_empty = 1'b1;
      hit_head  = '0;
      // A stalled request is replayed from the latched copy.
      cur_wre = (state_q == ST_WAIT) ? req_wre_q : cwb_wre_i;
      cur_adr = (state_q == ST_WAIT) ? req_adr_q : cwb_adr_i;
      cur_tga = (state_q == ST_WAIT) ? req_tga_q : cwb_tga_i;
      cur_dat = (state_q == ST_WAIT) ? req_dat_q : cwb_dat_i;
      for (int i = 0; i < NCH; i++) begin
         if (cur_adr == 5'(i)) begin
            ch_hit[i] = 1'b1;
            hit_full  = tx_full[i];
            hit_empty = rx_empty[i];
            hit_head  = rx_head[i];
         end
      end
      case (state_q)
         ST_IDLE, ST_WAIT: begin
            if (req_vld || state_q == ST_WAIT) begin
               req_wre_d = cur_wre;
               req_adr_d = cur_adr;
               req_tga_d = cur_tga;
               req_dat_d = cur_dat;
               state_d   = ST_ACK;
               ack_d     = 1'b1;
               if (ch_hit == '0) begin
                  dat_d          = '0;
                  tga_d          = '0;
                  tga_d[ST_FAIL] = 1'b1;
               end else if (cur_wre ? hit_full : hit_empty) begin
                  if (cur_tga[TGA_N]) begin
                     tga_d          = '0;
                     tga_d[ST_FAIL] = 1'b1;
                  end else begin
                     state_d = ST_WAIT;
                     ack_d   = 1'b0;
                  end
               end else if (cur_wre) begin
                  tx_push = ch_hit;
                  tga_d   = '0;
               end else begin
                  rx_pop         = ch_hit;
                  dat_d          = hit_head[31:0];
                  tga_d          = '0;
                  tga_d[ST_CMIS] = hit_head[FSL_W-1] ^ cur_tga[TGA_C];
               end
            end
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         ack_q     <= 1'b0;
         dat_q     <= '0;
         tga_q     <= '0;
         req_wre_q <= 1'b0;
         req_adr_q <= '0;
         req_tga_q <= '0;
         req_dat_q <= '0;
      end else begin
         state_q   <= state_d;
         ack_q     <= ack_d;
         dat_q     <= dat_d;
         tga_q     <= tga_d;
         req_wre_q <= req_wre_d;
         req_adr_q <= req_adr_d;
         req_tga_q <= req_tga_d;
         req_dat_q <= req_dat_d;
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
`ifdef AEMB2_FSL_OCCUPANCY_EN
      logic [AW:0] tx_cnt, rx_cnt;
      assign fsl_occ_o[g*2*(AW+1) +: 2*(AW+1)] = {tx_cnt, rx_cnt};
`endif

      aemb2_fsl_fifo #(.Depth(DEPTH), .Aw(AW)) u_tx (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .push_i  (tx_push[g]),
         .dat_i   ({cur_tga[TGA_C], cur_dat}),
         .pop_i   (fsl_tx_rdy_i[g]),
         .dat_o   (tx_head[g]),
         .full_o  (tx_full[g]),
         .empty_o (tx_empty[g])
`ifdef AEMB2_FSL_OCCUPANCY_EN
        ,.cnt_o   (tx_cnt)
`endif
      );

      aemb2_fsl_fifo #(.Depth(DEPTH), .Aw(AW)) u_rx (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .push_i  (fsl_rx_vld_i[g]),
         .dat_i   ({fsl_rx_ctl_i[g], fsl_rx_dat_i[g*32 +: 32]}),
         .pop_i   (rx_pop[g]),
         .dat_o   (rx_head[g]),
         .full_o  (rx_full[g]),
         .empty_o (rx_empty[g])
`ifdef AEMB2_FSL_OCCUPANCY_EN
        ,.cnt_o   (rx_cnt)
`endif
      );

      assign fsl_tx_dat_o[g*32 +: 32] = tx_head[g][31:0];
      assign fsl_tx_ctl_o[g]          = tx_head[g][FSL_W-1];
   end

`ifndef AEMB2_FSL_OCCUPANCY_EN
   assign fsl_occ_o = '0;
`endif

   assign fsl_tx_vld_o = ~tx_empty;
   assign fsl_rx_rdy_o = ~rx_full;

endmodule

// File: doc/aemb2_cwb_fsl.md
Name: aemb2_cwb_fsl

Overview:
- Responder end of the aeMB2 FSL bus (cwb) driven by the integer ASLU.
- Holds one put FIFO (core to device) and one get FIFO (device to core) per channel.
- Decodes cwb address and tag; stalls or acknowledges blocking/non-blocking put/get.
- Presents per-channel valid/ready streams to attached coprocessors.

Parameters:
- NCH, 4, number of implemented channels (1..32); addresses >= NCH are unmapped.
- DEPTH, 4, FIFO entries per direction per channel; power of two, >= 2.
- AW, 2, log2(DEPTH).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- cwb_stb_i  in  1  request strobe
- cwb_wre_i  in  1  1=put, 0=get
- cwb_adr_i  in  5  [6:2] channel number
- cwb_tga_i  in  2  [1]=n (non-blocking), [0]=c (control)
- cwb_sel_i  in  4  byte lanes; a request is valid only when sel=4'hF
- cwb_dat_i  in  32  put data
- cwb_dat_o  out  32  get data
- cwb_ack_o  out  1  acknowledge
- cwb_tga_o  out  2  status: [1]=fail (non-blocking miss or unmapped), [0]=control mismatch on get
- fsl_tx_dat_o  out  NCH*32  put FIFO head per channel
- fsl_tx_ctl_o  out  NCH  control bit of put head
- fsl_tx_vld_o  out  NCH  put FIFO non-empty
- fsl_tx_rdy_i  in  NCH  device pops put head
- fsl_rx_dat_i  in  NCH*32  device data into get FIFO
- fsl_rx_ctl_i  in  NCH  device control bit
- fsl_rx_vld_i  in  NCH  device pushes
- fsl_rx_rdy_o  out  NCH  get FIFO not full
- fsl_occ_o  out  NCH*2*(AW+1)  {tx_count, rx_count} per channel; see Optional Feature

Behaviour:
- Reset: all FIFOs empty; FSM=IDLE; cwb_ack_o=0, cwb_dat_o=0, cwb_tga_o=0; fsl_tx_vld_o=0; fsl_rx_rdy_o=all ones.
- FSM states:
  - IDLE: on valid request (stb & sel==F), evaluate:
    - unmapped channel: ACK, fail=1, dat_o=0.
    - put, FIFO not full: push {c,dat_i} at this edge; ACK, status 0.
    - get, FIFO not empty: pop at this edge; dat_o<=head data; mismatch=(head ctl != c); ACK.
    - put full / get empty, n=1: ACK, fail=1, no FIFO change, dat_o unchanged.
    - put full / get empty, n=0: go to WAIT.
  - WAIT: re-evaluate every cycle with the latched request. cwb_* inputs are held stable by the master while stb is high. Complete exactly as in IDLE once space/data exists.
  - ACK: cwb_ack_o=1 for exactly one cycle; stb is ignored in this cycle; return to IDLE.
- Latency: non-stalled request sampled at edge E0; ack high in the cycle after E0, i.e. 1 cycle.
- Pushed put data: fsl_tx_vld_o rises in the cycle after the push edge.
- FIFO rules (per channel):
  - Circular buffer with count AW+1 bits.
  - Push when full is ignored; device pushing with rdy_o=0 is dropped.
  - No fall-through: a word pushed at edge E is poppable from E+1 onward.
  - Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both performed.
  - Full blocks push even if a pop occurs in the same cycle.
  - Pointers wrap at DEPTH.
- cwb_tga_o and cwb_dat_o are valid only while ack=1; they hold their values otherwise.
- Reset mid-WAIT: abandon the request, no ack issued; FIFOs emptied.

Optional Feature:
- Macro AEMB2_FSL_OCCUPANCY_EN.
- Defined: fsl_occ_o carries registered per-channel counts (0..DEPTH), updated the cycle after each push/pop.
- Undefined: fsl_occ_o is tied to 0 and no extra logic is built; FIFO count registers are still used internally.

Decomposition:
- Package aemb2_fsl_pkg holds:
  - FSM state encoding (ST_IDLE, ST_WAIT, ST_ACK)
  - tag bit indices (TGA_N=1, TGA_C=0)
  - status bit indices (ST_FAIL=1, ST_CMIS=0)
  - FSL word width 33
- Sub-module aemb2_fsl_fifo: single 33-bit sync FIFO with push/pop/full/empty/count, instantiated 2*NCH times via generate.

Test Plan:
- Blocking put ch1 data 32'hDEADBEEF c=0 into empty FIFO -> ack 1 cycle later, tga_o=00; next cycle fsl_tx_vld_o[1]=1, tx_dat=DEADBEEF, tx_ctl=0.
- Device pushes 32'h12345678 ctl=1 on ch0; blocking get with c=0 -> ack, dat_o=12345678, tga_o=01; rx FIFO empty afterwards.
- Fill ch2 put FIFO with 4 words, 5th put n=1 -> ack, tga_o=10, count stays 4; same put with n=0 -> no ack until device pops one word (tx_rdy_i[2] pulse), then ack 1 cycle later.
- Get on ch3 (NCH=4) with empty FIFO, n=0 -> WAIT; assert rst_i for 1 cycle -> no ack, FIFOs empty, rx_rdy_o all ones.
- Request to channel 9 with NCH=4 -> ack, tga_o=10, dat_o=0; request with sel=4'h3 -> ignored, no ack.
- With AEMB2_FSL_OCCUPANCY_EN: 3 puts to ch0 plus 1 simultaneous device pop -> occ tx_count ch0 = 2; without the macro occ=0.
